// File: rtl/wload_pkg.sv
// Shared types for the systolic-array weight loader.
package wload_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wload.sv
// Weight loader: clears a PE column, then writes one streamed weight per row in order.
module wload
  import wload_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic signed [WIDTH-1:0] i_wdata,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic signed [WIDTH-1:0] o_data,
  output logic [ROWS-1:0]         o_en,
  output logic                    o_clr,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int CNT_W = $clog2(ROWS);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        row;
  logic signed [WIDTH-1:0] data_p1;
  logic [ROWS-1:0]         en_p1;
  logic                    accept;
  logic                    last_row;

  assign accept   = i_wvalid && o_wready;
  assign last_row = (row == CNT_W'(ROWS - 1));
  assign o_data   = data_p1;
  assign o_en     = en_p1;

  always_comb begin
    state_nxt = state;
    o_wready  = 1'b0;
    o_clr     = 1'b0;
    o_done    = 1'b0;
    o_busy    = (state != IDLE);
    case (state)
      IDLE:    if (i_start) state_nxt = CLEAR;
      CLEAR: begin
        o_clr     = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        o_wready = !i_abort;
        if (i_wvalid && !i_abort && last_row) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition, including a simultaneous start.
    if (i_abort) state_nxt = IDLE;
  end

  // Stage p1: registered row write (data + one-hot enable)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      data_p1 <= '0;
      en_p1   <= '0;
    end else begin
      state <= state_nxt;
      if (i_abort) begin
        en_p1 <= '0;
        row   <= '0;
      end else if (accept) begin
        data_p1 <= i_wdata;
        en_p1   <= ROWS'(1) << row;
        row     <= last_row ? '0 : row + 1'b1;
      end else begin
        en_p1 <= '0;
        if (state == CLEAR) row <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wload.sv
// Directed bench for wload with ROWS=4, WIDTH=16.
module tb_wload;

  localparam int WIDTH = 16;
  localparam int ROWS  = 4;

  logic                    clk;
  logic                    rst;
  logic                    i_start;
  logic                    i_abort;
  logic signed [WIDTH-1:0] i_wdata;
  logic                    i_wvalid;
  logic                    o_wready;
  logic signed [WIDTH-1:0] o_data;
  logic [ROWS-1:0]         o_en;
  logic                    o_clr;
  logic                    o_busy;
  logic                    o_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  wload #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_data(o_data), .o_en(o_en), .o_clr(o_clr), .o_busy(o_busy),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_start = 1'b1; i_abort = 1'b0; i_wvalid = 1'b1; i_wdata = 16'sd55;
    tick; tick;
    total_cnt++;
    if ({o_data, o_en, o_clr, o_wready, o_busy, o_done} !== '0)
      $display("FAIL reset_outputs: got data=%0d en=%b clr=%b rdy=%b busy=%b done=%b, want all 0",
               o_data, o_en, o_clr, o_wready, o_busy, o_done);
    else pass_cnt++;
    rst = 1'b0; i_start = 1'b0; i_wvalid = 1'b0;
    tick;
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL reset_start_ignored: got busy=%b, want 0", o_busy);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    logic signed [WIDTH-1:0] w [4];
    int edges;
    w = '{16'sd100, -16'sd3, 16'sd7, -16'sd32768};
    i_start = 1'b1;
    tick; edges = 1;
    i_start = 1'b0;
    total_cnt++;
    if ({o_clr, o_busy, o_wready, o_en} !== {1'b1, 1'b1, 1'b0, 4'b0000})
      $display("FAIL basic_clear: got clr=%b busy=%b rdy=%b en=%b, want clr=1 busy=1 rdy=0 en=0000",
               o_clr, o_busy, o_wready, o_en);
    else pass_cnt++;
    tick; edges++;
    total_cnt++;
    if ({o_clr, o_wready} !== 2'b01)
      $display("FAIL basic_load_entry: got clr=%b rdy=%b, want clr=0 rdy=1", o_clr, o_wready);
    else pass_cnt++;
    i_wvalid = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      i_wdata = w[i];
      tick; edges++;
      total_cnt++;
      if ({o_en, o_data, o_done} !== {4'b0001 << i, w[i], (i == ROWS - 1)})
        $display("FAIL basic_beat%0d: got en=%b data=%0d done=%b, want en=%b data=%0d done=%b",
                 i, o_en, o_data, o_done, 4'b0001 << i, w[i], (i == ROWS - 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (!(o_done === 1'b1 && edges == ROWS + 2))
      $display("FAIL basic_latency: got done=%b after %0d edges, want done=1 after %0d", o_done, edges, ROWS + 2);
    else pass_cnt++;
    i_wvalid = 1'b0;
    tick;
    total_cnt++;
    if ({o_done, o_busy, o_en, o_data} !== {1'b0, 1'b0, 4'b0000, -16'sd32768})
      $display("FAIL basic_idle_after: got done=%b busy=%b en=%b data=%0d, want 0 0 0000 -32768",
               o_done, o_busy, o_en, o_data);
    else pass_cnt++;
  endtask

  task automatic test_bubbles;
    logic                    v [7];
    logic signed [WIDTH-1:0] last;
    logic [3:0]              exp_en;
    logic                    exp_dn;
    int beat;
    v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    beat = 0; last = '0;
    i_start = 1'b1; tick; i_start = 1'b0; tick;
    for (int j = 0; j < 7; j++) begin
      i_wvalid = v[j];
      i_wdata  = v[j] ? WIDTH'(11 * (beat + 1)) : 16'sh7777;
      exp_en = 4'b0000; exp_dn = 1'b0;
      if (v[j]) begin
        exp_en = 4'b0001 << beat;
        last   = WIDTH'(11 * (beat + 1));
        beat++;
        exp_dn = (beat == ROWS);
      end
      tick;
      total_cnt++;
      if ({o_en, o_data, o_done} !== {exp_en, last, exp_dn})
        $display("FAIL bubble_cyc%0d: got en=%b data=%0d done=%b, want en=%b data=%0d done=%b",
                 j, o_en, o_data, o_done, exp_en, last, exp_dn);
      else pass_cnt++;
    end
    i_wvalid = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    i_start = 1'b1; tick; i_start = 1'b0; tick;
    i_wvalid = 1'b1;
    i_wdata = 16'sd5; tick;
    i_wdata = 16'sd6; tick;
    i_abort = 1'b1; i_wdata = 16'sd99;
    #1;
    total_cnt++;
    if (o_wready !== 1'b0) $display("FAIL abort_ready_gate: got rdy=%b, want 0", o_wready);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({o_busy, o_en, o_done, o_data} !== {1'b0, 4'b0000, 1'b0, 16'sd6})
      $display("FAIL abort_idle: got busy=%b en=%b done=%b data=%0d, want 0 0000 0 6",
               o_busy, o_en, o_done, o_data);
    else pass_cnt++;
    i_abort = 1'b0; i_wvalid = 1'b0;
    i_start = 1'b1; tick; i_start = 1'b0;
    total_cnt++;
    if (o_clr !== 1'b1) $display("FAIL abort_reclear: got clr=%b, want 1", o_clr);
    else pass_cnt++;
    tick;
    i_wvalid = 1'b1; i_wdata = 16'sd77; tick;
    total_cnt++;
    if ({o_en, o_data} !== {4'b0001, 16'sd77})
      $display("FAIL abort_restart_row0: got en=%b data=%0d, want en=0001 data=77", o_en, o_data);
    else pass_cnt++;
    i_wvalid = 1'b0; i_abort = 1'b1; tick; i_abort = 1'b0;
  endtask

  task automatic test_rst_mid;
    i_start = 1'b1; tick; i_start = 1'b0; tick;
    i_wvalid = 1'b1; i_wdata = 16'sd8; tick;
    rst = 1'b1; i_start = 1'b1; i_wdata = 16'sd55;
    tick;
    total_cnt++;
    if ({o_data, o_en, o_clr, o_wready, o_busy, o_done} !== '0)
      $display("FAIL rst_mid_outputs: got data=%0d en=%b clr=%b rdy=%b busy=%b done=%b, want all 0",
               o_data, o_en, o_clr, o_wready, o_busy, o_done);
    else pass_cnt++;
    tick;
    rst = 1'b0; i_start = 1'b0; i_wvalid = 1'b0;
    tick;
    total_cnt++;
    if ({o_busy, o_en} !== 5'b0) $display("FAIL rst_mid_release: got busy=%b en=%b, want 0 0000", o_busy, o_en);
    else pass_cnt++;
  endtask

  task automatic test_start_held;
    int dones;
    dones = 0;
    i_start = 1'b1; i_wvalid = 1'b1;
    tick; tick;
    for (int i = 0; i < ROWS; i++) begin
      i_wdata = WIDTH'(i + 1);
      tick;
      if (o_done === 1'b1) dones++;
    end
    tick;
    if (o_done === 1'b1) dones++;
    total_cnt++;
    if ({o_busy, dones} !== {1'b0, 32'd1})
      $display("FAIL held_one_tile: got busy=%b dones=%0d, want busy=0 dones=1", o_busy, dones);
    else pass_cnt++;
    tick;
    total_cnt++;
    if (o_clr !== 1'b1) $display("FAIL held_restart_clear: got clr=%b, want 1", o_clr);
    else pass_cnt++;
    i_abort = 1'b1;
    tick; tick;
    total_cnt++;
    if ({o_busy, o_clr} !== 2'b00)
      $display("FAIL start_abort_idle: got busy=%b clr=%b, want 0 0", o_busy, o_clr);
    else pass_cnt++;
    i_start = 1'b0; i_abort = 1'b0; i_wvalid = 1'b0;
  endtask

  task automatic test_extremes;
    logic signed [WIDTH-1:0] w [4];
    w = '{16'sd32767, -16'sd32768, 16'sd32767, -16'sd32768};
    i_wvalid = 1'b1; i_wdata = 16'sd1234;
    #1;
    total_cnt++;
    if (o_wready !== 1'b0) $display("FAIL idle_ready: got rdy=%b, want 0", o_wready);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({o_en, o_busy} !== 5'b0) $display("FAIL idle_no_accept: got en=%b busy=%b, want 0000 0", o_en, o_busy);
    else pass_cnt++;
    i_start = 1'b1; tick; i_start = 1'b0; tick;
    for (int i = 0; i < ROWS; i++) begin
      i_wdata = w[i];
      tick;
      total_cnt++;
      if ({o_en, o_data} !== {4'b0001 << i, w[i]})
        $display("FAIL extreme_beat%0d: got en=%b data=%0d, want en=%b data=%0d",
                 i, o_en, o_data, 4'b0001 << i, w[i]);
      else pass_cnt++;
    end
    i_wdata = 16'sd4321;
    total_cnt++;
    if ({o_done, o_wready} !== 2'b10)
      $display("FAIL done_ready: got done=%b rdy=%b, want done=1 rdy=0", o_done, o_wready);
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({o_en, o_data, o_busy} !== {4'b0000, -16'sd32768, 1'b0})
      $display("FAIL done_no_accept: got en=%b data=%0d busy=%b, want 0000 -32768 0", o_en, o_data, o_busy);
    else pass_cnt++;
    i_wvalid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bubbles;
    test_abort;
    test_rst_mid;
    test_start_held;
    test_extremes;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
